multi_star_boxer: RTL and testbench

//  Successor to the single-star top-level path. Raster-scans a pixel framebuffer through a 1-cycle-latency read port.

---
 rtl/multi_star_boxer_if.sv | 28 ++
 rtl/multi_star_boxer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_multi_star_boxer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_star_boxer_if.sv
// Bundles the framebuffer read port and the VGA plot port of multi_star_boxer.
//   master (boxer side): drives rd_en/rd_x/rd_y and x_out/y_out/col_out/plot; samples rd_data
//   slave  (framebuffer / vga_adapter side): the opposite directions
// Parameters X_W, Y_W, COL_W must match those of the attached multi_star_boxer.
interface multi_star_boxer_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int COL_W = 3
) ();
    logic             rd_en;
    logic [X_W-1:0]   rd_x;
    logic [Y_W-1:0]   rd_y;
    logic [COL_W-1:0] rd_data;
    logic [X_W-1:0]   x_out;
    logic [Y_W-1:0]   y_out;
    logic [COL_W-1:0] col_out;
    logic             plot;

    modport master (
        output rd_en, rd_x, rd_y, x_out, y_out, col_out, plot,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_x, rd_y, x_out, y_out, col_out, plot,
        output rd_data
    );
endinterface

// File: rtl/multi_star_boxer.sv
// multi_star_boxer
// Raster-scans a framebuffer through a 1-cycle-latency read port, groups lit
// pixels into up to MAX_STARS bounding boxes, then streams box-outline plot
// commands to the VGA adapter.
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   start      begin a run (only sampled in IDLE)
//   busy       high from SCAN through DRAW
//   done       single-cycle pulse at end of run
//   star_count boxes found in the current/last run
//   overflow   sticky per run: a lit pixel was dropped for lack of a slot
//   bus        multi_star_boxer_if.master (framebuffer read + plot port)
// Optional feature: define STAR_CENTRE_EN to also plot each box's centre pixel
// in CTR_COL (border colour wins when the centre lies on the border).
//
// State | meaning
// IDLE  | waiting for start
// SCAN  | issuing one framebuffer read per cycle in raster order
// FLUSH | consuming the read data of the final address
// DRAW  | walking each box, plotting its outline
// DONE  | one-cycle done pulse
module multi_star_boxer #(
    parameter int               X_W       = 8,
    parameter int               Y_W       = 7,
    parameter int               COL_W     = 3,
    parameter int               X_MAX     = 160,
    parameter int               Y_MAX     = 120,
    parameter int               MAX_STARS = 4,
    parameter int               MERGE_GAP = 1,
    parameter logic [COL_W-1:0] BOX_COL   = 3'b100,
    parameter logic [COL_W-1:0] CTR_COL   = 3'b010
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [3:0]          star_count,
    output logic                overflow,
    multi_star_boxer_if.master  bus
);

    typedef enum logic [2:0] {IDLE, SCAN, FLUSH, DRAW, DONE} stateType;

    localparam logic [X_W-1:0] X_LAST = X_W'(X_MAX - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX - 1);
    localparam logic [X_W:0]   GAP_X  = (X_W+1)'(MERGE_GAP);
    localparam logic [Y_W:0]   GAP_Y  = (Y_W+1)'(MERGE_GAP);

    stateType state, nextState;

    logic [X_W-1:0] scanX, pX;
    logic [Y_W-1:0] scanY, pY;
    logic           pValid;
    logic           lastAddr;

    logic [X_W-1:0] boxXl [MAX_STARS];
    logic [X_W-1:0] boxXr [MAX_STARS];
    logic [Y_W-1:0] boxYt [MAX_STARS];
    logic [Y_W-1:0] boxYb [MAX_STARS];
    logic [X_W-1:0] nXl   [MAX_STARS];
    logic [X_W-1:0] nXr   [MAX_STARS];
    logic [Y_W-1:0] nYt   [MAX_STARS];
    logic [Y_W-1:0] nYb   [MAX_STARS];
    logic [3:0]     boxCnt, cntNext;
    logic           ovfReg, ovfNext;

    logic [3:0]       drawIdx;
    logic [X_W-1:0]   walkX, curXl, curXr, nextXl;
    logic [Y_W-1:0]   walkY, curYt, curYb, nextYt;
    logic             boxEnd, lastBox, onBorder, isCtr, plotNow;
    logic [COL_W-1:0] colNow;
    logic [X_W-1:0]   xHold;
    logic [Y_W-1:0]   yHold;
    logic [COL_W-1:0] colHold;

    assign lastAddr = (scanX == X_LAST) && (scanY == Y_LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = SCAN;
            SCAN:    if (lastAddr) nextState = FLUSH;
            // cntNext includes a box possibly opened by the final pixel
            FLUSH:   nextState = (cntNext != 4'd0) ? DRAW : DONE;
            DRAW:    if (boxEnd && lastBox) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // ---------------- box grouping ----------------
    // Slots 0..boxCnt-1 are valid; slots fill contiguously so the count
    // doubles as the validity mask.
    always_comb begin
        logic           hitFound;
        logic [X_W:0]   xLo, xHi;
        logic [Y_W:0]   yLo, yHi;
        nXl      = boxXl;
        nXr      = boxXr;
        nYt      = boxYt;
        nYb      = boxYb;
        cntNext  = boxCnt;
        ovfNext  = ovfReg;
        hitFound = 1'b0;
        xLo      = '0;
        xHi      = '0;
        yLo      = '0;
        yHi      = '0;
        if (pValid && (bus.rd_data != '0)) begin
            for (int k = 0; k < MAX_STARS; k++) begin
                xLo = ({1'b0, boxXl[k]} >= GAP_X) ? ({1'b0, boxXl[k]} - GAP_X) : '0;
                xHi = {1'b0, boxXr[k]} + GAP_X;
                yLo = ({1'b0, boxYt[k]} >= GAP_Y) ? ({1'b0, boxYt[k]} - GAP_Y) : '0;
                yHi = {1'b0, boxYb[k]} + GAP_Y;
                if (!hitFound && (k < int'(boxCnt)) &&
                    ({1'b0, pX} >= xLo) && ({1'b0, pX} <= xHi) &&
                    ({1'b0, pY} >= yLo) && ({1'b0, pY} <= yHi)) begin
                    hitFound = 1'b1;
                    if (pX < boxXl[k]) nXl[k] = pX;
                    if (pX > boxXr[k]) nXr[k] = pX;
                    if (pY < boxYt[k]) nYt[k] = pY;
                    if (pY > boxYb[k]) nYb[k] = pY;
                end
            end
            if (!hitFound) begin
                if (boxCnt < 4'(MAX_STARS)) begin
                    for (int k = 0; k < MAX_STARS; k++) begin
                        if (4'(k) == boxCnt) begin
                            nXl[k] = pX;
                            nXr[k] = pX;
                            nYt[k] = pY;
                            nYb[k] = pY;
                        end
                    end
                    cntNext = boxCnt + 4'd1;
                end else begin
                    ovfNext = 1'b1;
                end
            end
        end
    end

    // ---------------- draw walk ----------------
    always_comb begin
        curXl  = '0;
        curXr  = '0;
        curYt  = '0;
        curYb  = '0;
        nextXl = '0;
        nextYt = '0;
        for (int k = 0; k < MAX_STARS; k++) begin
            if (4'(k) == drawIdx) begin
                curXl = boxXl[k];
                curXr = boxXr[k];
                curYt = boxYt[k];
                curYb = boxYb[k];
            end
            if (4'(k) == drawIdx + 4'd1) begin
                nextXl = boxXl[k];
                nextYt = boxYt[k];
            end
        end
    end

    assign boxEnd   = (walkX == curXr) && (walkY == curYb);
    assign lastBox  = (drawIdx == boxCnt - 4'd1);
    assign onBorder = (walkX == curXl) || (walkX == curXr) ||
                      (walkY == curYt) || (walkY == curYb);

`ifdef STAR_CENTRE_EN
    logic [X_W:0] sumX;
    logic [Y_W:0] sumY;
    assign sumX  = {1'b0, curXl} + {1'b0, curXr};
    assign sumY  = {1'b0, curYt} + {1'b0, curYb};
    assign isCtr = (walkX == sumX[X_W:1]) && (walkY == sumY[Y_W:1]);
`else
    assign isCtr = 1'b0;
`endif

    assign plotNow = (state == DRAW) && (onBorder || isCtr);
    assign colNow  = onBorder ? BOX_COL : CTR_COL;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scanX   <= '0;
            scanY   <= '0;
            pX      <= '0;
            pY      <= '0;
            pValid  <= 1'b0;
            boxCnt  <= '0;
            ovfReg  <= 1'b0;
            drawIdx <= '0;
            walkX   <= '0;
            walkY   <= '0;
            xHold   <= '0;
            yHold   <= '0;
            colHold <= '0;
            for (int k = 0; k < MAX_STARS; k++) begin
                boxXl[k] <= '0;
                boxXr[k] <= '0;
                boxYt[k] <= '0;
                boxYb[k] <= '0;
            end
        end else begin
            pValid <= (state == SCAN);
            pX     <= scanX;
            pY     <= scanY;

            if (state == IDLE && start) begin
                scanX  <= '0;
                scanY  <= '0;
                boxCnt <= '0;
                ovfReg <= 1'b0;
            end

            if (state == SCAN || state == FLUSH) begin
                boxXl  <= nXl;
                boxXr  <= nXr;
                boxYt  <= nYt;
                boxYb  <= nYb;
                boxCnt <= cntNext;
                ovfReg <= ovfNext;
            end

            if (state == SCAN) begin
                if (scanX == X_LAST) begin
                    scanX <= '0;
                    scanY <= scanY + 1'b1;
                end else begin
                    scanX <= scanX + 1'b1;
                end
            end

            if (state == FLUSH) begin
                drawIdx <= '0;
                walkX   <= nXl[0];
                walkY   <= nYt[0];
            end

            if (state == DRAW) begin
                if (walkX == curXr) begin
                    if (walkY == curYb) begin
                        drawIdx <= drawIdx + 4'd1;
                        walkX   <= nextXl;
                        walkY   <= nextYt;
                    end else begin
                        walkX <= curXl;
                        walkY <= walkY + 1'b1;
                    end
                end else begin
                    walkX <= walkX + 1'b1;
                end
            end

            if (plotNow) begin
                xHold   <= walkX;
                yHold   <= walkY;
                colHold <= colNow;
            end
        end
    end

    // ---------------- outputs ----------------
    assign busy        = (state == SCAN) || (state == FLUSH) || (state == DRAW);
    assign done        = (state == DONE);
    assign star_count  = boxCnt;
    assign overflow    = ovfReg;
    assign bus.rd_en   = (state == SCAN);
    assign bus.rd_x    = scanX;
    assign bus.rd_y    = scanY;
    assign bus.plot    = plotNow;
    assign bus.x_out   = plotNow ? walkX  : xHold;
    assign bus.y_out   = plotNow ? walkY  : yHold;
    assign bus.col_out = plotNow ? colNow : colHold;

endmodule

// File: tb/tb_multi_star_boxer.sv
// Scoreboard bench for multi_star_boxer on a reduced 64x64 frame.
module tb_multi_star_boxer;
    localparam int XM    = 64;
    localparam int YM    = 64;
    localparam int FRAME = XM * YM;
    localparam int BOX   = 4;
    localparam int CTR   = 2;

    typedef struct { int x; int y; int col; } plotExp;
    typedef struct { int cnt; int ovf; } doneExp;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic busy, done, overflow;
    logic [3:0] star_count;

    logic [2:0] fb [0:XM-1][0:YM-1];
    plotExp plotQ[$];
    doneExp doneQ[$];
    int total = 0;
    int bad = 0;

    multi_star_boxer_if #(.X_W(8), .Y_W(7), .COL_W(3)) bus ();

    multi_star_boxer #(.X_MAX(XM), .Y_MAX(YM)) dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .star_count(star_count), .overflow(overflow), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.rd_en) bus.rd_data <= fb[int'(bus.rd_x)][int'(bus.rd_y)];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: pop and compare whenever the DUT presents a plot or done
    always @(negedge clk) begin
        if (resetn && bus.plot) begin
            if (plotQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpectedPlot: got (%0d,%0d) expected none", bus.x_out, bus.y_out);
            end else begin
                plotExp e;
                e = plotQ.pop_front();
                check("plotX", int'(bus.x_out), e.x);
                check("plotY", int'(bus.y_out), e.y);
                check("plotCol", int'(bus.col_out), e.col);
            end
        end
        if (resetn && done) begin
            if (doneQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpectedDone: got done expected none");
            end else begin
                doneExp d;
                d = doneQ.pop_front();
                check("doneCount", int'(star_count), d.cnt);
                check("doneOverflow", int'(overflow), d.ovf);
            end
        end
    end

    task automatic clearFrame();
        for (int x = 0; x < XM; x++)
            for (int y = 0; y < YM; y++) fb[x][y] = 3'd0;
    endtask

    task automatic setPix(input int x, input int y);
        fb[x][y] = 3'd7;
    endtask

    task automatic expPlot(input int x, input int y, input int col);
        plotExp e;
        e.x = x; e.y = y; e.col = col;
        plotQ.push_back(e);
    endtask

    task automatic expDone(input int cnt, input int ovf);
        doneExp d;
        d.cnt = cnt; d.ovf = ovf;
        doneQ.push_back(d);
    endtask

    task automatic pulseStart();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // expCyc: negedges after the accepting edge until done is seen
    task automatic runFrame(input string name, input int expCyc, input int pokeAt,
                            input int cnt, input int ovf);
        int cyc;
        expDone(cnt, ovf);
        pulseStart();
        cyc = 0;
        while (cyc < expCyc + 50) begin
            @(negedge clk);
            cyc++;
            start = (cyc == pokeAt);
            if (done) break;
        end
        start = 1'b0;
        check({name, "_doneCycle"}, cyc, expCyc);
        repeat (3) @(negedge clk);
        check({name, "_leftoverPlots"}, plotQ.size(), 0);
        check({name, "_busyAfter"}, int'(busy), 0);
        check({name, "_countHeld"}, int'(star_count), cnt);
        check({name, "_ovfHeld"}, int'(overflow), ovf);
    endtask

    task automatic frame3x3();
        clearFrame();
        for (int x = 10; x <= 12; x++)
            for (int y = 20; y <= 22; y++) setPix(x, y);
        for (int y = 20; y <= 22; y++)
            for (int x = 10; x <= 12; x++) begin
                if (x == 10 || x == 12 || y == 20 || y == 22) expPlot(x, y, BOX);
`ifdef STAR_CENTRE_EN
                else expPlot(x, y, CTR);
`endif
            end
    endtask

    initial begin
        bit sawPlot;
        clearFrame();
        #3;
        check("rstBusy", int'(busy), 0);
        check("rstDone", int'(done), 0);
        check("rstPlot", int'(bus.plot), 0);
        check("rstRdEn", int'(bus.rd_en), 0);
        check("rstCount", int'(star_count), 0);
        check("rstOverflow", int'(overflow), 0);
        check("rstXout", int'(bus.x_out), 0);
        #20 resetn = 1'b1;
        repeat (2) @(negedge clk);

        // single 3x3 star
        frame3x3();
        runFrame("star3x3", FRAME + 1 + 9 + 1, 0, 1, 0);

        // diagonal neighbours merge into one 2x2 box
        clearFrame();
        setPix(50, 50); setPix(51, 51);
        expPlot(50, 50, BOX); expPlot(51, 50, BOX);
        expPlot(50, 51, BOX); expPlot(51, 51, BOX);
        runFrame("merge", FRAME + 1 + 4 + 1, 0, 1, 0);

        // gap of 3 pixels keeps two boxes
        clearFrame();
        setPix(50, 50); setPix(53, 50);
        expPlot(50, 50, BOX); expPlot(53, 50, BOX);
        runFrame("split", FRAME + 1 + 2 + 1, 0, 2, 0);

        // five isolated pixels, four slots
        clearFrame();
        for (int i = 0; i < 5; i++) setPix(5 + 10 * i, 5);
        for (int i = 0; i < 4; i++) expPlot(5 + 10 * i, 5, BOX);
        runFrame("overflow", FRAME + 1 + 4 + 1, 0, 4, 1);

        // empty frame, with a start pulse in mid-scan that must be ignored
        clearFrame();
        runFrame("empty", FRAME + 2, 100, 0, 0);

        // async reset in the middle of DRAW
        frame3x3();
        pulseStart();
        sawPlot = 0;
        for (int i = 0; i < FRAME + 20; i++) begin
            @(negedge clk);
            if (bus.plot) begin
                sawPlot = 1;
                break;
            end
        end
        check("reachedDraw", int'(sawPlot), 1);
        #2 resetn = 1'b0;
        #1;
        check("midRstPlot", int'(bus.plot), 0);
        check("midRstBusy", int'(busy), 0);
        check("midRstCount", int'(star_count), 0);
        plotQ.delete();
        doneQ.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // rescan after the reset
        frame3x3();
        runFrame("rescan", FRAME + 1 + 9 + 1, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
